// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message writer: the sequencer state
// encoding, block geometry constants and the byte-swap helper.
package sha1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        WR,
        PAD,
        ZERO,
        LEN_HI,
        LEN_LO,
        DONE
    } state_t;

    localparam int         SHA1_BLOCK_WORDS  = 16;
    localparam int         SHA1_LEN_WORD_IDX = 14;
    localparam logic [7:0] SHA1_PAD_BYTE     = 8'h80;

    // Memory words are little-endian by lane, while SHA-1 lengths are big-endian.
    function automatic logic [31:0] sha1_bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha1_word_packer.sv
// Collects a byte stream into 32-bit words, lane 0 in the low byte, and can
// drop the 0x80 terminator into the lane after the final byte.
module sha1_word_packer
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        mark_en,
    output logic [31:0] word,
    output logic [1:0]  lane
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clear) begin
            word_d = 32'h0;
            lane_d = 2'd0;
        end else if (accept) begin
            word_d[8*int'(lane_q) +: 8] = in_data;
            // Upper lanes are already zero because the word is cleared on every write.
            if (mark_en && in_last && (lane_q != 2'd3)) begin
                word_d[8*(int'(lane_q) + 1) +: 8] = SHA1_PAD_BYTE;
            end
            lane_d = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word_q <= 32'h0;
            lane_q <= 2'd0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word = word_q;
    assign lane = lane_q;

endmodule

// File: rtl/sha1_msg_writer.sv
// Streams a byte message into dual-port SRAM port A as 32-bit words.
// Define SHA1_WRITER_PAD_EN to append SHA-1 padding and the 64-bit bit length.
module sha1_msg_writer
    import sha1_pkg::*;
#(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        empty_msg,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        port_A_clk,
    output logic        port_A_we,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_written,
    output logic [31:0] message_size
);

    localparam logic [15:0] STEP       = 16'(ADDR_STEP);
    localparam logic [15:0] BLOCK_MASK = 16'(SHA1_BLOCK_WORDS - 1);
    localparam logic [15:0] LEN_IDX    = 16'(SHA1_LEN_WORD_IDX);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] words_q, words_d;
    logic [31:0] size_q, size_d;
    logic        last_q, last_d;

    logic        pk_clear;
    logic        pk_accept;
    logic        pk_mark_en;
    logic [31:0] pk_word;
    logic [1:0]  pk_lane;

    logic [15:0] words_inc;
    logic        at_len;

`ifdef SHA1_WRITER_PAD_EN
    assign pk_mark_en = 1'b1;
`else
    assign pk_mark_en = 1'b0;
`endif

    sha1_word_packer u_packer (
        .clk     (clk),
        .nreset  (nreset),
        .clear   (pk_clear),
        .accept  (pk_accept),
        .in_data (in_data),
        .in_last (in_last),
        .mark_en (pk_mark_en),
        .word    (pk_word),
        .lane    (pk_lane)
    );

    assign words_inc = words_q + 16'd1;
    assign at_len    = ((words_inc & BLOCK_MASK) == LEN_IDX);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        words_d        = words_q;
        size_d         = size_q;
        last_d         = last_q;
        pk_clear       = 1'b0;
        pk_accept      = 1'b0;
        in_ready       = 1'b0;
        port_A_we      = 1'b0;
        port_A_data_in = 32'h0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    addr_d   = base_addr;
                    words_d  = 16'd0;
                    size_d   = 32'd0;
                    last_d   = 1'b0;
                    pk_clear = 1'b1;
`ifdef SHA1_WRITER_PAD_EN
                    state_d  = empty_msg ? PAD : PACK;
`else
                    state_d  = empty_msg ? DONE : PACK;
`endif
                end
            end

            PACK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pk_accept = 1'b1;
                    size_d    = size_q + 32'd1;
                    if (in_last) begin
                        last_d = 1'b1;
                    end
                    if ((pk_lane == 2'd3) || in_last) begin
                        state_d = WR;
                    end
                end
            end

            WR: begin
                port_A_we      = 1'b1;
                port_A_data_in = pk_word;
                addr_d         = addr_q + STEP;
                words_d        = words_inc;
                pk_clear       = 1'b1;
                if (!last_q) begin
                    state_d = PACK;
                end else begin
`ifdef SHA1_WRITER_PAD_EN
                    // Lane counter wrapped to 0 means the last byte filled lane 3, so no room for 0x80.
                    if (pk_lane == 2'd0) begin
                        state_d = PAD;
                    end else begin
                        state_d = at_len ? LEN_HI : ZERO;
                    end
`else
                    state_d = DONE;
`endif
                end
            end

            PAD: begin
                port_A_we      = 1'b1;
                port_A_data_in = {24'h0, SHA1_PAD_BYTE};
                addr_d         = addr_q + STEP;
                words_d        = words_inc;
                state_d        = at_len ? LEN_HI : ZERO;
            end

            ZERO: begin
                port_A_we      = 1'b1;
                port_A_data_in = 32'h0;
                addr_d         = addr_q + STEP;
                words_d        = words_inc;
                state_d        = at_len ? LEN_HI : ZERO;
            end

            LEN_HI: begin
                port_A_we      = 1'b1;
                port_A_data_in = sha1_bswap32({29'h0, size_q[31:29]});
                addr_d         = addr_q + STEP;
                words_d        = words_inc;
                state_d        = LEN_LO;
            end

            LEN_LO: begin
                port_A_we      = 1'b1;
                port_A_data_in = sha1_bswap32({size_q[28:0], 3'b000});
                addr_d         = addr_q + STEP;
                words_d        = words_inc;
                state_d        = DONE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            addr_q  <= 16'h0;
            words_q <= 16'h0;
            size_q  <= 32'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            size_q  <= size_d;
            last_q  <= last_d;
        end
    end

    assign port_A_clk    = clk;
    assign port_A_addr   = addr_q;
    assign words_written = words_q;
    assign message_size  = size_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);

endmodule

// File: doc/sha1_msg_writer.md
SHA1_MSG_WRITER -- requirements
Module: sha1_msg_writer

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, byte-address increment per word written.
REQ-002 SHALL have ports: clk  in  1  system clock; nreset  in  1  asynchronous active-low reset.
REQ-003 SHALL have inputs: start 1 (begin a message); base_addr 16 (first word address); empty_msg 1 (sampled with start, zero-length message).
REQ-004 SHALL have a byte stream: in_data in 8; in_valid in 1; in_last in 1 (final byte); in_ready out 1.
REQ-005 SHALL have dpsram port A: port_A_clk out 1 (= clk); port_A_we out 1; port_A_addr out 16; port_A_data_in out 32.
REQ-006 SHALL have status outputs: busy 1; done 1; words_written 16; message_size 32 (bytes accepted).

Function
REQ-007 SHALL use states IDLE, PACK, WR, PAD, ZERO, LEN_HI, LEN_LO, DONE.
REQ-008 IDLE/DONE: start=1 SHALL latch base_addr, clear counters and go to PACK, or to PAD if empty_msg=1; start while busy SHALL be ignored.
REQ-009 PACK: in_ready=1; each accepted byte (in_valid&in_ready) SHALL go into lane L=count[1:0] at bits [8L+7:8L] and increment message_size.
REQ-010 Accepting the lane-3 byte or in_last SHALL move to WR; in_ready=0 outside PACK.
REQ-011 WR SHALL drive port_A_we=1 for exactly one cycle with the current address and word, then add ADDR_STEP to the address (mod 2^16) and increment words_written.
REQ-012 If in_last lands in lane L<3, that WR word SHALL carry 0x80 in lane L+1 and zeros above; if L=3, PAD SHALL write 0x00000080.
REQ-013 After the word containing 0x80, ZERO SHALL write 0x00000000 until words_written mod 16 == 14.
REQ-014 LEN_HI/LEN_LO SHALL write the 64-bit bit length (message_size*8) bytes most-significant first in ascending byte addresses, i.e. byte-swapped {29'b0,size[31:29]} then byte-swapped {size[28:0],3'b0}.
REQ-015 After LEN_LO, the block SHALL enter DONE: done=1, busy=0, words_written and message_size held until next start.
REQ-016 busy SHALL be 1 in every state except IDLE and DONE; port_A_we SHALL be 0 except on write cycles.
REQ-017 message_size SHALL wrap modulo 2^32; length words use the wrapped value.

Reset
REQ-018 nreset low SHALL asynchronously force IDLE and port_A_we=0, in_ready=0, busy=0, done=0, port_A_addr=0, port_A_data_in=0, words_written=0, message_size=0, including mid-message.
REQ-019 The first cycle after reset release SHALL accept start.

Configuration
REQ-020 With SHA1_WRITER_PAD_EN defined, REQ-012 to REQ-014 SHALL apply.
REQ-021 Without SHA1_WRITER_PAD_EN, no 0x80/zero/length words SHALL be written: the last WR holds zeros above the last lane, then DONE; empty_msg goes straight to DONE with words_written=0.

Structure
REQ-022 Shared package sha1_pkg SHALL hold the state enum, SHA1_BLOCK_WORDS=16, SHA1_LEN_WORD_IDX=14, SHA1_PAD_BYTE=8'h80 and the byte-swap function.
REQ-023 Byte-lane packing SHALL be a sub-module sha1_word_packer; sequencing and padding stay in the top.

Verification
REQ-024 "abc" (0x61,0x62,0x63, last on 0x63), base 0x0100 -> 0x0100=0x80636261, 0x0104-0x0134 zero, 0x0138=0x00000000, 0x013C=0x18000000, words_written=16, message_size=3.
REQ-025 "abcd" -> 0x64636261, 0x00000080, 12 zero words, 0x00000000, 0x20000000; words_written=16.
REQ-026 56-byte message -> 14 data words, 0x80 word at index 14, zeros to index 29, index 31=0xC0010000; words_written=32.
REQ-027 empty_msg=1 with start -> 0x00000080, 15 zero words, done=1, words_written=16, message_size=0.
REQ-028 nreset pulsed after 2 bytes of "abc" -> port_A_we=0 in same cycle, all outputs zero; new start of "abc" then gives REQ-024 result.
REQ-029 Without SHA1_WRITER_PAD_EN, "abc" -> single write 0x00636261, words_written=1, done=1; start asserted while busy has no effect.
